// File: rtl/exa_crosb_input_arbiter_vc_aging.sv
`default_nettype none
// ============================================================================
//  Module      : exa_crosb_input_arbiter_vc_aging
//  Description : Per-input crossbar arbiter. Picks one input VC whose target
//                output FIFO VC has credit, requests the destination output
//                arbiter and holds clear-to-send until the last beat.
//                Multi-priority, per-priority round-robin, aging promotion.
//  Revision    : 1.0  initial release
// ============================================================================
module exa_crosb_input_arbiter_vc_aging #(
    parameter  int prio_num     = 2,
    parameter  int vc_num       = 3,
    parameter  int output_num   = 8,
    parameter  int starve_limit = 16,
    localparam int NV  = prio_num * vc_num,
    localparam int LV  = (NV > 1) ? $clog2(NV) : 1,
    localparam int LO  = (output_num > 1) ? $clog2(output_num) : 1,
    localparam int LA  = (starve_limit > 0) ? $clog2(starve_limit + 1) : 1,
    localparam int LP  = (prio_num > 1) ? $clog2(prio_num) : 1,
    localparam int LVV = (vc_num > 1) ? $clog2(vc_num) : 1
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NV-1:0]                     i_has_packet,
    input  logic [LO-1:0]                     i_dest [NV],
    input  logic [NV-1:0][LV-1:0]             i_output_vc,
    input  logic [output_num-1:0][NV-1:0]     i_output_fifo_credits,
    input  logic [output_num-1:0]             i_grant,
    input  logic                              i_last,
    output logic [output_num-1:0]             o_request,
    output logic [LV-1:0]                     o_request_vc,
    output logic                              o_cts,
    output logic [LV-1:0]                     o_selected_vc,
    output logic                              o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [NV-1:0]  eligible;
    logic [LA-1:0]  age [NV];
    logic [LVV-1:0] rr_ptr [prio_num];

    logic [LV-1:0]  sel_vc;
    logic [LO-1:0]  sel_dest;
    logic [LV-1:0]  sel_ovc;
    logic [LP-1:0]  sel_prio;
    logic [LVV-1:0] sel_v;

    logic           win_found;
    logic           aged_found;
    logic [LV-1:0]  win_vc;
    logic [LP-1:0]  win_prio;
    logic [LVV-1:0] win_v;
    int             rr_idx;

    logic           grant_hit;
    logic           credit_ok;

    // A VC is eligible when its head packet exists and its target output VC has credit
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NV; i++) begin
            eligible[i] = i_has_packet[i] & i_output_fifo_credits[i_dest[i]][i_output_vc[i]];
        end
    end

    // Winner selection: starved VC (lowest index) first, else round-robin in highest busy priority
    always_comb begin
        win_found  = |eligible;
        aged_found = 1'b0;
        win_vc     = '0;
        win_prio   = '0;
        win_v      = '0;
        rr_idx     = 0;
        if (starve_limit > 0) begin
            for (int i = NV - 1; i >= 0; i--) begin
                if (eligible[i] && (age[i] == LA'(starve_limit))) begin
                    aged_found = 1'b1;
                    win_vc     = LV'(i);
                    win_prio   = LP'(i / vc_num);
                    win_v      = LVV'(i % vc_num);
                end
            end
        end
        if (!aged_found) begin
            // ascending priority and descending offset: later matches override earlier ones
            for (int p = 0; p < prio_num; p++) begin
                for (int k = vc_num; k >= 1; k--) begin
                    rr_idx = (int'(rr_ptr[p]) + k) % vc_num;
                    if (eligible[p * vc_num + rr_idx]) begin
                        win_vc   = LV'(p * vc_num + rr_idx);
                        win_prio = LP'(p);
                        win_v    = LVV'(rr_idx);
                    end
                end
            end
        end
    end

    assign grant_hit = (state == REQ) && i_grant[sel_dest];
    assign credit_ok = i_output_fifo_credits[sel_dest][sel_ovc];

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; a grant takes precedence over a credit loss
    always_comb begin
        state_next = state;
        o_request  = '0;
        o_cts      = 1'b0;
        o_busy     = (state != IDLE);
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                o_request[sel_dest] = 1'b1;
                if (grant_hit) begin
                    state_next = XFER;
                end else if (!credit_ok) begin
                    state_next = IDLE;
                end
            end
            XFER: begin
                o_cts = 1'b1;
                if (i_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the winner in IDLE; advance its priority's pointer only on an actual grant
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_vc   <= '0;
            sel_dest <= '0;
            sel_ovc  <= '0;
            sel_prio <= '0;
            sel_v    <= '0;
            for (int p = 0; p < prio_num; p++) begin
                rr_ptr[p] <= LVV'(vc_num - 1);
            end
        end else begin
            if ((state == IDLE) && win_found) begin
                sel_vc   <= win_vc;
                sel_dest <= i_dest[win_vc];
                sel_ovc  <= i_output_vc[win_vc];
                sel_prio <= win_prio;
                sel_v    <= win_v;
            end
            if (grant_hit) begin
                rr_ptr[sel_prio] <= sel_v;
            end
        end
    end

    // Aging: waiting lower-priority VCs count higher-priority grants, saturating at the limit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NV; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NV; i++) begin
                if (!i_has_packet[i]) begin
                    age[i] <= '0;
                end else if (grant_hit) begin
                    if (LV'(i) == sel_vc) begin
                        age[i] <= '0;
                    end else if (eligible[i] && ((i / vc_num) < int'(sel_prio))
                                 && (age[i] != LA'(starve_limit))) begin
                        age[i] <= age[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign o_request_vc  = sel_ovc;
    assign o_selected_vc = sel_vc;

endmodule
`default_nettype wire

// File: tb/tb_exa_crosb_input_arbiter_vc_aging.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exa_crosb_input_arbiter_vc_aging
//  Description : Self-checking bench for exa_crosb_input_arbiter_vc_aging
//                (default parameters: 2 priorities x 3 VCs, 8 outputs,
//                starvation limit 16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_exa_crosb_input_arbiter_vc_aging;

    logic            clk;
    logic            resetn;
    logic [5:0]      has_packet;
    logic [2:0]      dest [6];
    logic [5:0][2:0] output_vc;
    logic [7:0][5:0] credits;
    logic [7:0]      grant;
    logic            last;
    logic [7:0]      request;
    logic [2:0]      request_vc;
    logic            cts;
    logic [2:0]      selected_vc;
    logic            busy;

    exa_crosb_input_arbiter_vc_aging dut (
        .clk                   (clk),
        .resetn                (resetn),
        .i_has_packet          (has_packet),
        .i_dest                (dest),
        .i_output_vc           (output_vc),
        .i_output_fifo_credits (credits),
        .i_grant               (grant),
        .i_last                (last),
        .o_request             (request),
        .o_request_vc          (request_vc),
        .o_cts                 (cts),
        .o_selected_vc         (selected_vc),
        .o_busy                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] has;
        logic [7:0] gnt;
        logic       lst;
        logic [7:0] req;
        logic [2:0] rvc;
        logic [2:0] sel;
        logic       cts;
        logic       busy;
    } vec_t;

    typedef struct {
        int         tag;
        logic [7:0] req;
        logic [2:0] rvc;
        logic [2:0] sel;
        logic       cts;
        logic       busy;
    } exp_t;

    exp_t  sb[$];
    int    tests = 0;
    int    fails = 0;
    int    step  = 0;
    string phase = "init";

    task automatic push_exp(input logic [7:0] er, input logic [2:0] ervc,
                            input logic [2:0] es, input logic ec, input logic eb);
        exp_t e;
        e.tag  = step;
        e.req  = er;
        e.rvc  = ervc;
        e.sel  = es;
        e.cts  = ec;
        e.busy = eb;
        sb.push_back(e);
        step++;
    endtask

    task automatic check_out();
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s: scoreboard empty, got req=%b sel=%0d", phase, request, selected_vc);
        end else begin
            e = sb.pop_front();
            if (request !== e.req || request_vc !== e.rvc || selected_vc !== e.sel ||
                cts !== e.cts || busy !== e.busy) begin
                fails++;
                $display("FAIL %s[%0d]: got req=%b rvc=%0d sel=%0d cts=%b busy=%b, expected req=%b rvc=%0d sel=%0d cts=%b busy=%b",
                         phase, e.tag, request, request_vc, selected_vc, cts, busy,
                         e.req, e.rvc, e.sel, e.cts, e.busy);
            end
        end
    endtask

    // drive one cycle of stimulus, queue its expected result, check after the edge
    task automatic apply(input logic [5:0] h, input logic [7:0] g, input logic l,
                         input logic [7:0] er, input logic [2:0] ervc, input logic [2:0] es,
                         input logic ec, input logic eb);
        has_packet = h;
        grant      = g;
        last       = l;
        push_exp(er, ervc, es, ec, eb);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic defaults();
        has_packet = '0;
        grant      = '0;
        last       = 1'b0;
        credits    = '1;
        for (int i = 0; i < 6; i++) begin
            dest[i]      = 3'd1;
            output_vc[i] = 3'(i);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t tbl[15];

    initial begin
        // basic service order, ignored grant bits and ignored last in IDLE
        tbl[0]  = '{6'h00, 8'h00, 1'b1, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{6'h07, 8'h00, 1'b0, 8'h02, 3'd0, 3'd0, 1'b0, 1'b1};
        tbl[2]  = '{6'h07, 8'hFD, 1'b0, 8'h02, 3'd0, 3'd0, 1'b0, 1'b1};
        tbl[3]  = '{6'h07, 8'hFF, 1'b0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b1};
        tbl[4]  = '{6'h07, 8'h02, 1'b0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b1};
        tbl[5]  = '{6'h07, 8'h00, 1'b1, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0};
        tbl[6]  = '{6'h07, 8'h00, 1'b0, 8'h02, 3'd1, 3'd1, 1'b0, 1'b1};
        tbl[7]  = '{6'h07, 8'h02, 1'b0, 8'h00, 3'd1, 3'd1, 1'b1, 1'b1};
        tbl[8]  = '{6'h07, 8'h00, 1'b1, 8'h00, 3'd1, 3'd1, 1'b0, 1'b0};
        tbl[9]  = '{6'h07, 8'h00, 1'b0, 8'h02, 3'd2, 3'd2, 1'b0, 1'b1};
        tbl[10] = '{6'h07, 8'h02, 1'b0, 8'h00, 3'd2, 3'd2, 1'b1, 1'b1};
        tbl[11] = '{6'h07, 8'h00, 1'b1, 8'h00, 3'd2, 3'd2, 1'b0, 1'b0};
        tbl[12] = '{6'h07, 8'h00, 1'b0, 8'h02, 3'd0, 3'd0, 1'b0, 1'b1};
        tbl[13] = '{6'h07, 8'h02, 1'b0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b1};
        tbl[14] = '{6'h07, 8'h00, 1'b1, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0};

        defaults();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        phase = "reset";
        push_exp(8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        check_out();

        phase = "table";
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].has, tbl[i].gnt, tbl[i].lst,
                  tbl[i].req, tbl[i].rvc, tbl[i].sel, tbl[i].cts, tbl[i].busy);
        end

        // high priority wins; VC0 promoted on the 17th arbitration
        phase = "aging";
        defaults();
        do_reset();
        for (int n = 1; n <= 18; n++) begin
            logic [2:0] es;
            es = (n == 17) ? 3'd0 : 3'd5;
            apply(6'h21, 8'h00, 1'b0, 8'h02, es, es, 1'b0, 1'b1);
            apply(6'h21, 8'h02, 1'b0, 8'h00, es, es, 1'b1, 1'b1);
            apply(6'h21, 8'h00, 1'b1, 8'h00, es, es, 1'b0, 1'b0);
        end

        // credit withdrawal while requesting: back to IDLE, pointer untouched
        phase = "credit_drop";
        defaults();
        dest[3] = 3'd4;
        do_reset();
        apply(6'h08, 8'h00, 1'b0, 8'h10, 3'd3, 3'd3, 1'b0, 1'b1);
        credits[4][3] = 1'b0;
        apply(6'h08, 8'h00, 1'b0, 8'h00, 3'd3, 3'd3, 1'b0, 1'b0);
        apply(6'h08, 8'h00, 1'b0, 8'h00, 3'd3, 3'd3, 1'b0, 1'b0);
        credits[4][3] = 1'b1;
        apply(6'h18, 8'h00, 1'b0, 8'h10, 3'd3, 3'd3, 1'b0, 1'b1);

        // grant and credit loss together: grant wins, later credit loss ignored
        phase = "grant_vs_credit";
        credits[4][3] = 1'b0;
        apply(6'h18, 8'h10, 1'b0, 8'h00, 3'd3, 3'd3, 1'b1, 1'b1);
        apply(6'h18, 8'h00, 1'b0, 8'h00, 3'd3, 3'd3, 1'b1, 1'b1);
        apply(6'h18, 8'h00, 1'b1, 8'h00, 3'd3, 3'd3, 1'b0, 1'b0);
        credits[4][3] = 1'b1;
        phase = "rr_advance";
        apply(6'h18, 8'h00, 1'b0, 8'h02, 3'd4, 3'd4, 1'b0, 1'b1);
        apply(6'h18, 8'h02, 1'b0, 8'h00, 3'd4, 3'd4, 1'b1, 1'b1);
        apply(6'h00, 8'h00, 1'b1, 8'h00, 3'd4, 3'd4, 1'b0, 1'b0);

        // all grant bits set while requesting dest 2
        phase = "grant_ff";
        dest[0] = 3'd2;
        apply(6'h01, 8'h00, 1'b0, 8'h04, 3'd0, 3'd0, 1'b0, 1'b1);
        apply(6'h01, 8'hFF, 1'b0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b1);

        // asynchronous reset in the middle of a transfer
        phase = "async_reset";
        resetn = 1'b0;
        #1;
        push_exp(8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        check_out();
        #1;
        resetn = 1'b1;
        dest[0] = 3'd1;
        phase = "after_reset";
        apply(6'h07, 8'h00, 1'b0, 8'h02, 3'd0, 3'd0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
